fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_fifo.sv | 70 +++++++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the reset fetch address, the NOP encoding, the fetch FSM state
// encoding and the fetch-queue entry layout used by fetch_stage and fetch_fifo.
package fetch_stage_pkg;

  // Default first fetch address after reset.
  localparam logic [31:0] FS_RESET_PC = 32'h0000_0000;

  // Instruction word presented in IF/ID whenever it holds no real instruction.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default fetch-queue depth (also the in-flight request limit).
  localparam int unsigned FS_FQ_DEPTH = 4;

  // RUN: responses are kept. DRAIN: responses belonging to a squashed
  // fetch path are still outstanding and get dropped as they return.
  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_t;

  // One fetch-queue entry: instruction word plus its address + 4.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fq_entry_t;

  // Sequential fetch address; wraps naturally from 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched instructions until IF/ID takes them.
// Latency: a push is visible at the head on the next cycle (no bypass).
// Backpressure: none internally; the producer must never push when full.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - empties the FIFO (takes effect like reset)
//   push, push_data     - write one entry
//   pop                 - discard the head entry (ignored when empty)
//   pop_data            - current head entry (valid when !empty)
//   count, empty        - occupancy
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // A push into a full queue is a design error upstream; it is refused so
  // that stored entries are never corrupted, and flagged by the assertion.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        assert (!full);
      end
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: issues sequential instruction fetches and feeds the IF/ID register.
// Latency: a response arriving in cycle t reaches IF/ID in cycle t+2 (via the fetch queue).
// Backpressure: requests stop while in-flight + queued reaches FQ_DEPTH; stall holds IF/ID.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   stall_PC_IFID                 - load-use stall: hold IF/ID and the queue head
//   branch_taken, branch_target   - redirect from EX (wins over stall)
//   imem_req, imem_addr           - request to instruction memory (addr = PC)
//   imem_ready                    - memory accepts the request this cycle
//   imem_rvalid, imem_rdata       - in-order response from instruction memory
//   if_id_valid, if_id_instr,     - IF/ID register contents (NOP when invalid)
//   if_id_pc4
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FS_RESET_PC,
  parameter int unsigned FQ_DEPTH = FS_FQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_PC_IFID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  localparam int CW  = $clog2(FQ_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_W = CW1'(FQ_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;       // address of the next response that will be kept
  logic [CW-1:0] inflight;      // accepted requests whose response has not returned
  logic [CW-1:0] discard_cnt;   // outstanding responses that belong to a squashed path
  logic [CW-1:0] discard_nxt;
  fetch_state_t  state;

  logic [CW-1:0] fq_count;
  logic          fq_empty;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_keep;
  logic          fq_pop;
  fq_entry_t     fq_in;
  fq_entry_t     fq_out;

  // Every in-flight request may land in the queue, so the pair together
  // never exceeds the queue depth and the queue cannot overflow.
  assign occupancy = {1'b0, inflight} + {1'b0, fq_count};
  assign imem_req  = !rst && !branch_taken && (occupancy < DEPTH_W);
  assign imem_addr = pc;
  assign req_fire  = imem_req && imem_ready;

  // Responses are kept only when nothing is left to discard; a response
  // arriving with a redirect is older than the redirect and is dropped.
  assign rsp_keep = imem_rvalid && (state == FS_RUN) && !branch_taken;
  assign fq_pop   = !stall_PC_IFID && !branch_taken && !fq_empty;

  assign fq_in.instr = imem_rdata;
  assign fq_in.pc4   = pc_plus4(resp_pc);

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (64)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (rsp_keep),
    .push_data (fq_in),
    .pop       (fq_pop),
    .pop_data  (fq_out),
    .count     (fq_count),
    .empty     (fq_empty)
  );

  // On a redirect every outstanding request is stale, except a response
  // consumed in this very cycle. In DRAIN this is the remaining discard
  // count (less this cycle's drop) plus the live in-flight requests,
  // which reduces to the same expression.
  always_comb begin
    discard_nxt = discard_cnt;
    if (branch_taken) begin
      discard_nxt = inflight - CW'(imem_rvalid);
    end else if (imem_rvalid && (state == FS_DRAIN)) begin
      discard_nxt = discard_cnt - CW'(1);
    end
  end

  // Drain FSM: DRAIN while stale responses are still outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FS_RUN;
      discard_cnt <= '0;
    end else begin
      discard_cnt <= discard_nxt;
      case (state)
        FS_RUN:   if (discard_nxt != '0) state <= FS_DRAIN;
        FS_DRAIN: if (discard_nxt == '0) state <= FS_RUN;
        default:  state <= FS_RUN;
      endcase
    end
  end

  // PC advances only on accepted requests. A load-use stall does not
  // touch it directly: the queue absorbs fetched words, and once it is
  // full imem_req drops, which holds the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rvalid);

      if (branch_taken)  pc <= branch_target;
      else if (req_fire) pc <= pc_plus4(pc);

      if (branch_taken)  resp_pc <= branch_target;
      else if (rsp_keep) resp_pc <= pc_plus4(resp_pc);
    end
  end

  // IF/ID register: redirect squashes, stall holds, otherwise take the
  // queue head or insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
    end else if (branch_taken) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (!stall_PC_IFID) begin
      if (!fq_empty) begin
        if_id_valid <= 1'b1;
        if_id_instr <= fq_out.instr;
        if_id_pc4   <= fq_out.pc4;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule
